fractal_dispatch: RTL and testbench

FRACTAL_DISPATCH -- requirements
Module: fractal_dispatch

---
 rtl/fractal_dispatch.sv | 121 ++++++++++++
 tb/tb_fractal_dispatch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_dispatch.sv
// Two-engine pixel dispatcher: hands raster coordinates to alternating engines and
// retires their results strictly in raster order toward the pixel packer.
module fractal_dispatch #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        out_stream_aclk,
    input  logic        periph_reset,
    input  logic        enable,
    output logic [1:0]  eng_start,
    output logic [9:0]  eng_x,
    output logic [8:0]  eng_y,
    input  logic [1:0]  eng_ready,
    input  logic [1:0]  eng_rvalid,
    input  logic [15:0] eng_riter,
    output logic [1:0]  eng_rack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_iter,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_done
);

    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    typedef enum logic {
        ENG_FREE = 1'b0,
        ENG_BUSY = 1'b1
    } eng_state_t;

    eng_state_t eng_state      [2];
    eng_state_t eng_state_next [2];
    logic [1:0] busy;

    logic       dp, rp;
    logic [9:0] dx, rx;
    logic [8:0] dy, ry;
    logic       dispatch, retire;

    // NOTE: every signal driven here gets a default before any conditional update,
    // otherwise the unassigned paths would infer latches.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = (eng_state[i] == ENG_BUSY);
        end

        // busy is the registered value, so a freshly racked engine restarts a cycle later
        dispatch  = !periph_reset && enable && eng_ready[dp] && !busy[dp];
        eng_start = '0;
        if (dispatch) begin
            eng_start[dp] = 1'b1;
        end
        eng_x = dx;
        eng_y = dy;

        // Only the engine at the retire pointer may present, keeping raster order
        out_valid = eng_rvalid[rp] && busy[rp];
        out_iter  = rp ? eng_riter[15:8] : eng_riter[7:0];
        out_sof   = (rx == '0) && (ry == '0);
        out_eol   = (rx == X_LAST);
        retire    = out_valid && out_ready;
        eng_rack  = '0;
        if (retire) begin
            eng_rack[rp] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eng_state_next[i] = eng_state[i];
            case (eng_state[i])
                ENG_FREE: if (eng_start[i]) eng_state_next[i] = ENG_BUSY;
                ENG_BUSY: if (eng_rack[i])  eng_state_next[i] = ENG_FREE;
                default:                    eng_state_next[i] = ENG_FREE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            for (int i = 0; i < 2; i++) begin
                eng_state[i] <= ENG_FREE;
            end
            dp         <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            rp         <= 1'b0;
            rx         <= '0;
            ry         <= '0;
            frame_done <= 1'b0;
        end else begin
            eng_state  <= eng_state_next;
            frame_done <= retire && (rx == X_LAST) && (ry == Y_LAST);

            if (dispatch) begin
                dp <= ~dp;
                if (dx == X_LAST) begin
                    dx <= '0;
                    dy <= (dy == Y_LAST) ? '0 : dy + 9'd1;
                end else begin
                    dx <= dx + 10'd1;
                end
            end

            if (retire) begin
                rp <= ~rp;
                if (rx == X_LAST) begin
                    rx <= '0;
                    ry <= (ry == Y_LAST) ? '0 : ry + 9'd1;
                end else begin
                    rx <= rx + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fractal_dispatch.sv
// Bench for fractal_dispatch on a 4x2 frame: behavioural engines plus a raster-order
// scoreboard derived from pixel counts, directed scenarios followed by random traffic.
module tb_fractal_dispatch;

    localparam int XS = 4;
    localparam int YS = 2;
    localparam int NPIX = XS * YS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  eng_start;
    logic [9:0]  eng_x;
    logic [8:0]  eng_y;
    logic [1:0]  eng_ready = '0;
    logic [1:0]  eng_rvalid = '0;
    logic [15:0] eng_riter = '0;
    logic [1:0]  eng_rack;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_iter;
    logic        out_sof;
    logic        out_eol;
    logic        frame_done;

    always #5 clk = ~clk;

    fractal_dispatch #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .out_stream_aclk (clk),
        .periph_reset    (rst),
        .enable          (enable),
        .eng_start       (eng_start),
        .eng_x           (eng_x),
        .eng_y           (eng_y),
        .eng_ready       (eng_ready),
        .eng_rvalid      (eng_rvalid),
        .eng_riter       (eng_riter),
        .eng_rack        (eng_rack),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_iter        (out_iter),
        .out_sof         (out_sof),
        .out_eol         (out_eol),
        .frame_done      (frame_done)
    );

    // Behavioural engine: idle -> computing for a latency -> holding a result until racked
    typedef enum int {E_IDLE, E_COMP, E_DONE} est_t;
    est_t       est   [2];
    int         ecnt  [2];
    logic [7:0] eiter [2];
    int         lat   [2];
    bit         ready_mask [2];
    bit         rand_lat;
    bit         use_ovr;
    logic [7:0] ovr_iter [2];

    logic [1:0] start_seen, rack_seen;
    logic [9:0] seen_x;
    logic [8:0] seen_y;
    int         n_disp, n_ret, fd_count;
    bit         fd_exp;
    int         n_assert, n_fail;

    function automatic logic [7:0] f_iter(int x, int y);
        return 8'((x * 29 + y * 71 + 3) % 256);
    endfunction

    function automatic logic [7:0] exp_iter(int n);
        return use_ovr ? ovr_iter[n % 2] : f_iter(n % XS, (n / XS) % YS);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_engines();
        for (int e = 0; e < 2; e++) begin
            eng_ready[e]  = (est[e] == E_IDLE) && ready_mask[e];
            eng_rvalid[e] = (est[e] == E_DONE);
        end
        eng_riter = {eiter[1], eiter[0]};
    endtask

    task automatic reset_engines();
        for (int e = 0; e < 2; e++) begin
            est[e]   = E_IDLE;
            ecnt[e]  = 0;
            eiter[e] = '0;
        end
        drive_engines();
    endtask

    // One clock: check outputs at the falling edge, then advance engines after the rising edge
    task automatic tick();
        int k, kr, l;
        logic [1:0] exp_start, exp_rack;
        bit exp_valid;
        @(negedge clk);
        start_seen = '0;
        rack_seen  = '0;
        if (rst) begin
            check("rst_start", 32'(eng_start), 32'd0);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_rack",  32'(eng_rack),  32'd0);
            check("rst_fdone", 32'(frame_done), 32'd0);
            n_disp = 0;
            n_ret  = 0;
            fd_exp = 1'b0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(fd_exp));
            if (frame_done) fd_count++;
            fd_exp = 1'b0;

            k = n_disp % 2;
            exp_start = (enable && eng_ready[k]) ? 2'(1 << k) : 2'b00;
            check("eng_start", 32'(eng_start), 32'(exp_start));
            if (eng_start != 2'b00) begin
                check("eng_x", 32'(eng_x), 32'(n_disp % XS));
                check("eng_y", 32'(eng_y), 32'((n_disp / XS) % YS));
                check("lead",  32'(n_disp - n_ret < 2), 32'd1);
                start_seen = eng_start;
                seen_x = eng_x;
                seen_y = eng_y;
                n_disp++;
            end

            kr = n_ret % 2;
            exp_valid = eng_rvalid[kr];
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            exp_rack = (exp_valid && out_ready) ? 2'(1 << kr) : 2'b00;
            check("eng_rack", 32'(eng_rack), 32'(exp_rack));
            if (out_valid) begin
                check("out_iter", 32'(out_iter), 32'(exp_iter(n_ret)));
                check("out_sof",  32'(out_sof),  32'((n_ret % NPIX) == 0));
                check("out_eol",  32'(out_eol),  32'((n_ret % XS) == XS - 1));
            end
            if (eng_rack != 2'b00) begin
                rack_seen = eng_rack;
                if ((n_ret % NPIX) == NPIX - 1) fd_exp = 1'b1;
                n_ret++;
            end
        end

        @(posedge clk);
        #1;
        for (int e = 0; e < 2; e++) begin
            if (rack_seen[e]) est[e] = E_IDLE;
            if (start_seen[e]) begin
                l = rand_lat ? int'($urandom_range(0, 4)) : lat[e];
                eiter[e] = use_ovr ? ovr_iter[e] : f_iter(int'(seen_x), int'(seen_y));
                ecnt[e]  = l;
                est[e]   = (l == 0) ? E_DONE : E_COMP;
            end else if (est[e] == E_COMP) begin
                ecnt[e]--;
                if (ecnt[e] == 0) est[e] = E_DONE;
            end
        end
        drive_engines();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        reset_engines();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ret(int target, int budget, string tag);
        for (int i = 0; i < budget && n_ret < target; i++) tick();
        check(tag, 32'(n_ret >= target), 32'd1);
    endtask

    initial begin
        int d0, r0;
        n_assert = 0;
        n_fail   = 0;
        fd_count = 0;
        ready_mask = '{1'b1, 1'b1};
        lat        = '{8, 1};
        ovr_iter   = '{8'd200, 8'd7};
        use_ovr    = 1'b1;
        rand_lat   = 1'b0;
        out_ready  = 1'b1;
        reset_engines();
        repeat (2) @(posedge clk);
        #1;
        tick();

        // Reset release: engine 0 gets (0,0), engine 1 gets (1,0), then nothing until a rack
        enable = 1'b1;
        rst    = 1'b0;
        tick();
        check("first_disp", 32'(n_disp), 32'd1);
        tick();
        check("second_disp", 32'(n_disp), 32'd2);
        tick();
        tick();
        check("no_third_disp", 32'(n_disp), 32'd2);

        // Engine 1 (iter 7) finishes first; output must still be 200 with sof, then 7
        wait_ret(2, 40, "order_timeout");

        // Backpressure with both results held
        out_ready = 1'b0;
        lat = '{1, 1};
        for (int i = 0; i < 30 && !(n_disp - n_ret == 2 && eng_rvalid == 2'b11); i++) tick();
        check("both_held", 32'(n_disp - n_ret), 32'd2);
        d0 = n_disp;
        r0 = n_ret;
        repeat (10) tick();
        check("hold_no_disp", 32'(n_disp), 32'(d0));
        check("hold_no_ret",  32'(n_ret),  32'(r0));
        out_ready = 1'b1;
        repeat (4) tick();

        // Full 4x2 frame plus first pixel of the next one
        do_reset();
        use_ovr  = 1'b0;
        rand_lat = 1'b1;
        fd_count = 0;
        wait_ret(NPIX + 1, 200, "frame_timeout");
        check("frame_done_once", 32'(fd_count), 32'd1);

        // enable drops after three dispatches
        do_reset();
        for (int i = 0; i < 50 && n_disp < 3; i++) tick();
        enable = 1'b0;
        repeat (40) tick();
        check("en_drop_disp", 32'(n_disp), 32'd3);
        check("en_drop_ret",  32'(n_ret),  32'd3);

        // Reset while both engines hold results
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b0;
        rand_lat  = 1'b0;
        for (int i = 0; i < 20 && !(n_disp == 2 && eng_rvalid == 2'b11); i++) tick();
        check("busy_both", 32'(n_disp), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_rack",  32'(eng_rack),  32'd0);
        check("arst_start", 32'(eng_start), 32'd0);
        tick();
        reset_engines();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_disp", 32'(n_disp), 32'd1);

        // Random traffic
        rand_lat = 1'b1;
        for (int c = 0; c < 600; c++) begin
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ready_mask[0] = ($urandom_range(0, 5) != 0);
            ready_mask[1] = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            else tick();
        end
        enable     = 1'b0;
        out_ready  = 1'b1;
        ready_mask = '{1'b1, 1'b1};
        repeat (30) tick();
        check("drain", 32'(n_ret), 32'(n_disp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
